reg_block_collector: RTL and testbench

- Parametrised successor to the single-load 64-bit register.
- Collects DEPTH words of WIDTH bits, presented one per cycle, into a single DEPTH*WIDTH-bit block register. It then presents the whole block downstream with a valid/ready handshake.
- Sits between the message word source and the SHA-256 compression core. The default configuration assembles one 512-bit block from 16 32-bit words.

---
 rtl/reg_block_collector.sv | 78 +++++++
 tb/tb_reg_block_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_block_collector.sv
// Collects DEPTH words of WIDTH bits into one block register and hands the
// complete block downstream over a valid/ready handshake.
module reg_block_collector #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   clear,
  output logic                   ready_o,
  output logic [WIDTH*DEPTH-1:0] block_o,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  output logic [CNT_W-1:0]       word_cnt_o
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH*DEPTH-1:0] r_block;
  logic                   w_last;

  assign w_last = (r_cnt == CNT_W'(DEPTH - 1));

  // Block assembly and handshake; clear beats every other input.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_block <= '0;
    end else if (clear) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_block <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (start) begin
            // Slot k sits below k earlier words, so word 0 lands in the MSBs.
            for (int s = 0; s < DEPTH; s++) begin
              if (r_cnt == CNT_W'(s)) begin
                r_block[(DEPTH-1-s)*WIDTH +: WIDTH] <= data_i;
              end
            end
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= FULL;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (block_ready_i) begin
            r_state <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign ready_o       = (r_state == FILL);
  assign block_valid_o = (r_state == FULL);
  assign block_o       = r_block;
  assign word_cnt_o    = r_cnt;

endmodule

// File: tb/tb_reg_block_collector.sv
// Directed bench: default 32x16 collector plus a 64x2 instance driven from a vector table.
module tb_reg_block_collector;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic         start1 = 1'b0, clear1 = 1'b0, bready1 = 1'b0;
  logic [31:0]  data1 = 32'h0;
  logic         ready1, valid1;
  logic [511:0] block1;
  logic [4:0]   cnt1;

  logic         start2 = 1'b0, clear2 = 1'b0, bready2 = 1'b0;
  logic [63:0]  data2 = 64'h0;
  logic         ready2, valid2;
  logic [127:0] block2;
  logic [1:0]   cnt2;

  reg_block_collector #(.WIDTH(32), .DEPTH(16)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .data_i(data1), .clear(clear1),
    .ready_o(ready1), .block_o(block1), .block_valid_o(valid1),
    .block_ready_i(bready1), .word_cnt_o(cnt1)
  );

  reg_block_collector #(.WIDTH(64), .DEPTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .data_i(data2), .clear(clear2),
    .ready_o(ready2), .block_o(block2), .block_valid_o(valid2),
    .block_ready_i(bready2), .word_cnt_o(cnt2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic         start;
    logic [63:0]  data;
    logic         bready;
    logic         clr;
    logic         exp_valid;
    logic         exp_ready;
    logic [1:0]   exp_cnt;
    logic [127:0] exp_block;
  } vec_t;

  localparam logic [63:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] B = 64'h5555_5555_5555_5555;
  localparam logic [63:0] C = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] Z = 64'h0;

  vec_t tbl[13];
  logic [511:0] exp_blk;

  initial begin
    tbl[0]  = '{1'b1, A, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, {A, Z}};
    tbl[1]  = '{1'b1, B, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, {A, B}};
    tbl[2]  = '{1'b1, C, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, {A, B}};
    tbl[3]  = '{1'b0, C, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, {A, B}};
    tbl[4]  = '{1'b1, B, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, {B, B}};
    tbl[5]  = '{1'b1, A, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, {B, A}};
    tbl[6]  = '{1'b1, C, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, {B, A}};
    tbl[7]  = '{1'b1, A, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, {A, A}};
    tbl[8]  = '{1'b1, B, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, {A, B}};
    tbl[9]  = '{1'b1, A, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, {A, B}};
    tbl[10] = '{1'b1, A, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, {Z, Z}};
    tbl[11] = '{1'b1, B, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, {B, Z}};
    tbl[12] = '{1'b0, A, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, {Z, Z}};

    // Reset state while RST is low
    #12;
    check("rst_block", block1, 512'h0);
    check("rst_valid", {511'h0, valid1}, 512'h0);
    check("rst_ready", {511'h0, ready1}, 512'h1);
    check("rst_cnt", {507'h0, cnt1}, 512'h0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Continuous fill of 16 words
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      start1 = 1'b1;
      data1  = 32'(i + 1);
      exp_blk[(15-i)*32 +: 32] = 32'(i + 1);
      tick();
      check("fill_cnt", {507'h0, cnt1}, (i == 15) ? 512'h0 : 512'(i + 1));
      check("fill_valid", {511'h0, valid1}, (i == 15) ? 512'h1 : 512'h0);
    end
    check("fill_block", block1, exp_blk);
    check("fill_msw", {480'h0, block1[511:480]}, 512'h1);
    check("fill_lsw", {480'h0, block1[31:0]}, 512'h10);

    // Backpressure: FULL ignores start while block_ready_i is low
    data1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_block", block1, exp_blk);
      check("bp_ready", {511'h0, ready1}, 512'h0);
      check("bp_cnt", {507'h0, cnt1}, 512'h0);
      check("bp_valid", {511'h0, valid1}, 512'h1);
    end
    start1  = 1'b0;
    bready1 = 1'b1;
    tick();
    bready1 = 1'b0;
    check("consume_valid", {511'h0, valid1}, 512'h0);
    check("consume_ready", {511'h0, ready1}, 512'h1);
    check("consume_keep", block1, exp_blk);

    // Gapped fill: count moves only on start edges
    for (int i = 0; i < 16; i++) begin
      start1 = 1'b1;
      data1  = 32'(i + 1);
      tick();
      check("gap_cnt_on", {507'h0, cnt1}, (i == 15) ? 512'h0 : 512'(i + 1));
      start1 = 1'b0;
      data1  = 32'hFFFF_FFFF;
      if (i != 15) begin
        tick();
        check("gap_cnt_off", {507'h0, cnt1}, 512'(i + 1));
      end
    end
    check("gap_valid", {511'h0, valid1}, 512'h1);
    check("gap_block", block1, exp_blk);
    bready1 = 1'b1;
    tick();
    bready1 = 1'b0;

    // Clear mid-block with a concurrent start
    for (int i = 0; i < 7; i++) begin
      start1 = 1'b1;
      data1  = 32'h100 + 32'(i);
      tick();
    end
    check("pre_clr_cnt", {507'h0, cnt1}, 512'h7);
    data1  = 32'h0BAD_0BAD;
    clear1 = 1'b1;
    tick();
    clear1 = 1'b0;
    check("clr_cnt", {507'h0, cnt1}, 512'h0);
    check("clr_block", block1, 512'h0);
    check("clr_ready", {511'h0, ready1}, 512'h1);
    data1 = 32'h77;
    tick();
    start1 = 1'b0;
    check("post_clr_slot0", block1, {32'h77, 480'h0});
    check("post_clr_cnt", {507'h0, cnt1}, 512'h1);

    // Asynchronous reset mid-block
    start1 = 1'b1;
    data1  = 32'h55;
    tick();
    start1 = 1'b0;
    #3;
    RST = 1'b0;
    #1;
    check("arst_block", block1, 512'h0);
    check("arst_cnt", {507'h0, cnt1}, 512'h0);
    check("arst_valid", {511'h0, valid1}, 512'h0);
    check("arst_ready", {511'h0, ready1}, 512'h1);
    #2;
    RST = 1'b1;
    tick();
    start1 = 1'b1;
    data1  = 32'h99;
    tick();
    start1 = 1'b0;
    check("arst_slot0", block1, {32'h99, 480'h0});
    check("arst_cnt1", {507'h0, cnt1}, 512'h1);

    // 64x2 instance: table of per-cycle vectors
    for (int v = 0; v < 13; v++) begin
      start2  = tbl[v].start;
      data2   = tbl[v].data;
      bready2 = tbl[v].bready;
      clear2  = tbl[v].clr;
      tick();
      check($sformatf("v%0d_valid", v), {511'h0, valid2}, {511'h0, tbl[v].exp_valid});
      check($sformatf("v%0d_ready", v), {511'h0, ready2}, {511'h0, tbl[v].exp_ready});
      check($sformatf("v%0d_cnt", v), {510'h0, cnt2}, {510'h0, tbl[v].exp_cnt});
      check($sformatf("v%0d_block", v), {384'h0, block2}, {384'h0, tbl[v].exp_block});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
